// File: rtl/fwd_sel_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : fwd_sel_ctrl_if
// Purpose  : Bundles the decode-side request signals and the forwarding and
//            stall results exchanged with fwd_sel_ctrl.
// Ports    : none (parameterised signal bundle)
//   slave  : hazard controller side
//            inputs: hold, flush, id_*
//            outputs: sel_a, sel_b, stall, stall_cnt
//   master : pipeline / decode side (directions mirrored)
// Revision : 1.0 - initial release
// ============================================================================
interface fwd_sel_ctrl_if #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) ();

    logic                  hold;
    logic                  flush;
    logic                  id_valid;
    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic                  id_rs1_used;
    logic                  id_rs2_used;
    logic [REG_ADDR_W-1:0] id_rd;
    logic                  id_reg_write;
    logic                  id_is_load;
    logic [1:0]            sel_a;
    logic [1:0]            sel_b;
    logic                  stall;
    logic [CNT_W-1:0]      stall_cnt;

    modport slave (
        input  hold, flush, id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
               id_rd, id_reg_write, id_is_load,
        output sel_a, sel_b, stall, stall_cnt
    );

    modport master (
        output hold, flush, id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
               id_rd, id_reg_write, id_is_load,
        input  sel_a, sel_b, stall, stall_cnt
    );

endinterface : fwd_sel_ctrl_if
`default_nettype wire

// File: rtl/fwd_sel_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fwd_sel_ctrl
// Purpose  : Forwarding-select and load-use hazard controller for a 6-stage
//            pipeline. Tracks the destinations of the instructions in the EX,
//            MEM and WB slots, produces registered 2-bit ALU operand mux
//            selects (00 regfile, 01 EX/MEM, 10 MEM/WB, 11 WB bypass),
//            a combinational decode stall, and a saturating stall counter.
// Ports    : clk       - clock, all state updates on the rising edge
//            rst       - synchronous active-high reset
//            ctrl_if   - fwd_sel_ctrl_if.slave bundle (hold, flush, decode
//                        instruction fields in; sel_a, sel_b, stall,
//                        stall_cnt out)
// Options  : FWD_ZERO_REG_FILTER_EN - when defined, register x0 is never
//            forwarded and never causes a stall.
// Revision : 1.0 - initial release
// ============================================================================
module fwd_sel_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) (
    input  wire logic            clk,
    input  wire logic            rst,
    fwd_sel_ctrl_if.slave        ctrl_if
);

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic                  reg_write;
        logic                  is_load;
    } slot_t;

    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    slot_t            ex_q,  ex_d;
    slot_t            mem_q, mem_d;
    slot_t            wb_q,  wb_d;
    logic [1:0]       sel_a_q, sel_a_d;
    logic [1:0]       sel_b_q, sel_b_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stall;

    // A producer slot supplies the operand only if it is live, writes a
    // register, and that register is the one the decode instruction reads.
    function automatic logic slot_match(slot_t s, logic [REG_ADDR_W-1:0] rs,
                                        logic used);
        logic hit;
        hit = s.valid && s.reg_write && used && (s.rd == rs);
`ifdef FWD_ZERO_REG_FILTER_EN
        hit = hit && (s.rd != '0);
`endif
        return hit;
    endfunction

    // Youngest producer wins: check EX first, then MEM, then WB.
    function automatic logic [1:0] fwd_sel(slot_t ex_s, slot_t mem_s,
                                           slot_t wb_s,
                                           logic [REG_ADDR_W-1:0] rs,
                                           logic used);
        logic [1:0] sel;
        sel = 2'b00;
        if (slot_match(ex_s, rs, used)) begin
            sel = 2'b01;
        end else if (slot_match(mem_s, rs, used)) begin
            sel = 2'b10;
        end else if (slot_match(wb_s, rs, used)) begin
            sel = 2'b11;
        end
`ifdef FWD_ZERO_REG_FILTER_EN
        if (rs == '0) begin
            sel = 2'b00;
        end
`endif
        return sel;
    endfunction

    // Only a load in EX forces a bubble; anything further ahead is
    // already forwardable from a pipeline latch.
    always_comb begin
        stall = ctrl_if.id_valid && !ctrl_if.flush && !ctrl_if.hold &&
                ex_q.is_load &&
                (slot_match(ex_q, ctrl_if.id_rs1, ctrl_if.id_rs1_used) ||
                 slot_match(ex_q, ctrl_if.id_rs2, ctrl_if.id_rs2_used));
    end

    always_comb begin
        ex_d    = ex_q;
        mem_d   = mem_q;
        wb_d    = wb_q;
        sel_a_d = sel_a_q;
        sel_b_d = sel_b_q;
        cnt_d   = cnt_q;

        if (!ctrl_if.hold) begin
            wb_d  = mem_q;
            mem_d = ex_q;
            if (stall || ctrl_if.flush || !ctrl_if.id_valid) begin
                ex_d    = '0;
                sel_a_d = 2'b00;
                sel_b_d = 2'b00;
            end else begin
                ex_d.valid     = 1'b1;
                ex_d.rd        = ctrl_if.id_rd;
                ex_d.reg_write = ctrl_if.id_reg_write;
                ex_d.is_load   = ctrl_if.id_is_load;
                sel_a_d = fwd_sel(ex_q, mem_q, wb_q, ctrl_if.id_rs1,
                                  ctrl_if.id_rs1_used);
                sel_b_d = fwd_sel(ex_q, mem_q, wb_q, ctrl_if.id_rs2,
                                  ctrl_if.id_rs2_used);
            end
            // stall already excludes hold; counter saturates without wrap.
            if (stall && (cnt_q != c_cnt_max)) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q    <= '0;
            mem_q   <= '0;
            wb_q    <= '0;
            sel_a_q <= 2'b00;
            sel_b_q <= 2'b00;
            cnt_q   <= '0;
        end else begin
            ex_q    <= ex_d;
            mem_q   <= mem_d;
            wb_q    <= wb_d;
            sel_a_q <= sel_a_d;
            sel_b_q <= sel_b_d;
            cnt_q   <= cnt_d;
        end
    end

    // The WB slot's load flag is carried for slot uniformity only; nothing
    // downstream of WB needs it.
    logic w_unused;
    assign w_unused = wb_q.is_load;

    assign ctrl_if.sel_a     = sel_a_q;
    assign ctrl_if.sel_b     = sel_b_q;
    assign ctrl_if.stall     = stall;
    assign ctrl_if.stall_cnt = cnt_q;

endmodule : fwd_sel_ctrl
`default_nettype wire
